welcome_screen_ctrl: RTL and testbench

Frame-synchronous sequencer for the welcome screen. It positions and gates the title bitmap drawer and the blinking "press start" prompt. It moves the title through scroll-in, idle-blink and scroll-out phases and hands control to the game with a one-cycle start pulse. It sits between the keypad decoder and the title/prompt drawers, and feeds their top-left coordinates and enables.

---
 rtl/welcome_screen_ctrl.sv | 153 +++++++++++++++
 tb/tb_welcome_screen_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/welcome_screen_ctrl.sv
// welcome_screen_ctrl: frame-synchronous welcome screen sequencer
//   Moves the title through scroll-in, blink and scroll-out phases, then
//   hands the display to the game with a one-cycle start pulse.
// Ports:
//   i_clk              system clock
//   i_reset            synchronous active-high reset
//   i_start_of_frame   one-cycle pulse per video frame
//   i_start_key        debounced start key level
//   i_game_over        one-cycle pulse requesting return to the welcome screen
//   o_title_top_left_x title X (constant TITLE_X)
//   o_title_top_left_y title Y, signed two's complement
//   o_title_enable     title drawer may draw
//   o_prompt_enable    prompt drawer may draw
//   o_welcome_active   welcome screen owns the display
//   o_game_start       one-cycle pulse when the game begins
//   o_state            current state code
module welcome_screen_ctrl #(
    parameter int TITLE_X      = 170,
    parameter int TITLE_H      = 100,
    parameter int TARGET_Y     = 150,
    parameter int SCROLL_STEP  = 4,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start_of_frame,
    input  logic               i_start_key,
    input  logic               i_game_over,
    output logic [10:0]        o_title_top_left_x,
    output logic signed [10:0] o_title_top_left_y,
    output logic               o_title_enable,
    output logic               o_prompt_enable,
    output logic               o_welcome_active,
    output logic               o_game_start,
    output logic [2:0]         o_state
);
    localparam int CW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic signed [10:0] Y_MIN  = -11'(TITLE_H);
    localparam logic signed [10:0] Y_TGT  = 11'(TARGET_Y);
    localparam logic signed [10:0] Y_STEP = 11'(SCROLL_STEP);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SCROLL_IN  = 3'd1,
        S_BLINK      = 3'd2,
        S_SCROLL_OUT = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    state_t              r_state;
    logic signed [10:0]  r_y;
    logic [CW-1:0]       r_blink_cnt;
    logic                r_key_prev;
    logic                r_key_pending;
    logic                r_title_en;
    logic                r_prompt_en;
    logic                r_welcome;
    logic                r_game_start;
    logic                w_edge;
    logic                w_key;
    logic                w_wrap;
    logic signed [10:0]  w_up;
    logic signed [10:0]  w_dn;

    // A key edge arriving in the frame cycle itself still counts for that frame
    assign w_edge = i_start_key & ~r_key_prev;
    assign w_key  = w_edge | r_key_pending;
    assign w_wrap = r_blink_cnt == CW'(BLINK_FRAMES - 1);
    assign w_up   = r_y + Y_STEP;
    assign w_dn   = r_y - Y_STEP;

    assign o_title_top_left_x = 11'(TITLE_X);
    assign o_title_top_left_y = r_y;
    assign o_title_enable     = r_title_en;
    assign o_prompt_enable    = r_prompt_en;
    assign o_welcome_active   = r_welcome;
    assign o_game_start       = r_game_start;
    assign o_state            = r_state;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_y           <= Y_MIN;
            r_blink_cnt   <= '0;
            r_key_prev    <= 1'b0;
            r_key_pending <= 1'b0;
            r_title_en    <= 1'b0;
            r_prompt_en   <= 1'b0;
            r_welcome     <= 1'b1;
            r_game_start  <= 1'b0;
        end else begin
            r_key_prev    <= i_start_key;
            r_game_start  <= 1'b0;
            // Pending presses only matter while a key can still skip or exit
            r_key_pending <= (r_state == S_SCROLL_OUT || r_state == S_DONE) ? 1'b0 : (r_key_pending | w_edge);
            if (r_state == S_DONE) begin
                if (i_game_over) begin
                    r_state       <= S_IDLE;
                    r_welcome     <= 1'b1;
                    r_key_pending <= 1'b0;
                end
            end else if (i_start_of_frame) begin
                case (r_state)
                    S_IDLE: begin
                        r_state       <= S_SCROLL_IN;
                        r_title_en    <= 1'b1;
                        r_key_pending <= 1'b0;
                    end
                    S_SCROLL_IN: begin
                        if (w_key || w_up >= Y_TGT) begin
                            r_y           <= Y_TGT;
                            r_state       <= S_BLINK;
                            r_prompt_en   <= 1'b1;
                            r_blink_cnt   <= '0;
                            r_key_pending <= 1'b0;
                        end else begin
                            r_y <= w_up;
                        end
                    end
                    S_BLINK: begin
                        if (w_key) begin
                            r_state       <= S_SCROLL_OUT;
                            r_prompt_en   <= 1'b0;
                            r_key_pending <= 1'b0;
                        end else begin
                            r_blink_cnt <= w_wrap ? '0 : r_blink_cnt + 1'b1;
                            r_prompt_en <= w_wrap ? ~r_prompt_en : r_prompt_en;
                        end
                    end
                    S_SCROLL_OUT: begin
                        if (w_dn <= Y_MIN) begin
                            r_y          <= Y_MIN;
                            r_state      <= S_DONE;
                            r_title_en   <= 1'b0;
                            r_welcome    <= 1'b0;
                            r_game_start <= 1'b1;
                        end else begin
                            r_y <= w_dn;
                        end
                    end
                    default: begin
                        r_state       <= S_IDLE;
                        r_y           <= Y_MIN;
                        r_title_en    <= 1'b0;
                        r_prompt_en   <= 1'b0;
                        r_welcome     <= 1'b1;
                        r_key_pending <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_welcome_screen_ctrl.sv
// tb_welcome_screen_ctrl: randomized self-checking bench for welcome_screen_ctrl
module tb_welcome_screen_ctrl;
    localparam int TX = 170, TH = 100, TY = 150, ST = 4, BF = 30;

    logic clk = 1'b0;
    logic rst, sof, key, go;
    logic [10:0] x;
    logic signed [10:0] y;
    logic te, pe, wa, gs;
    logic [2:0] st;
    logic [17:0] act;

    welcome_screen_ctrl #(.TITLE_X(TX), .TITLE_H(TH), .TARGET_Y(TY), .SCROLL_STEP(ST), .BLINK_FRAMES(BF)) dut (
        .i_clk(clk), .i_reset(rst), .i_start_of_frame(sof), .i_start_key(key), .i_game_over(go),
        .o_title_top_left_x(x), .o_title_top_left_y(y), .o_title_enable(te), .o_prompt_enable(pe),
        .o_welcome_active(wa), .o_game_start(gs), .o_state(st)
    );

    always #5 clk = ~clk;
    assign act = {st, y, te, pe, wa, gs};

    int n_checks = 0, n_fail = 0;
    int m_state, m_y, m_bf;
    bit m_prev, m_pend, m_gs;

    // Reference: phase number, integer Y, and frames spent in the blink phase
    function automatic void model_step(bit s, bit k, bit g, bit r);
        bit e, kd, ent;
        if (r) begin
            m_state = 0; m_y = -TH; m_bf = 0; m_prev = 0; m_pend = 0; m_gs = 0;
            return;
        end
        e = k && !m_prev;
        kd = e || m_pend;
        ent = 0;
        m_gs = 0;
        if (m_state == 4) begin
            if (g) begin m_state = 0; ent = 1; end
        end else if (s) begin
            if (m_state == 0) begin
                m_state = 1; ent = 1;
            end else if (m_state == 1) begin
                m_y = kd ? TY : ((m_y + ST < TY) ? m_y + ST : TY);
                if (m_y == TY) begin m_state = 2; m_bf = 0; ent = 1; end
            end else if (m_state == 2) begin
                if (kd) begin m_state = 3; ent = 1; end
                else m_bf++;
            end else begin
                m_y -= ST;
                if (m_y <= -TH) begin m_y = -TH; m_state = 4; m_gs = 1; ent = 1; end
            end
        end
        m_pend = (ent || m_state >= 3) ? 0 : (m_pend || e);
        m_prev = k;
    endfunction

    function automatic logic [17:0] exp_vec();
        bit ete, epe, ewa;
        ete = m_state >= 1 && m_state <= 3;
        epe = m_state == 2 && ((m_bf / BF) % 2 == 0);
        ewa = m_state != 4;
        return {3'(m_state), 11'(m_y), ete, epe, ewa, m_gs};
    endfunction

    task automatic cycle(input bit s, input bit k, input bit g, input bit r);
        sof = s; key = k; go = g; rst = r;
        model_step(s, k, g, r);
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input bit k);
        repeat ($urandom_range(0, 2)) cycle(0, k, 0, 0);
        cycle(1, k, 0, 0);
    endtask

    task automatic test_reset();
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        n_checks++;
        if (act !== exp_vec()) begin n_fail++; $display("FAIL reset_vec got %h exp %h", act, exp_vec()); end
        n_checks++;
        if (st !== 3'd0 || y !== -11'sd100 || x !== 11'd170 || {te, pe, wa, gs} !== 4'b0010) begin
            n_fail++; $display("FAIL reset_values got st=%0d y=%0d x=%0d flags=%b exp st=0 y=-100 x=170 flags=0010", st, y, x, {te, pe, wa, gs});
        end
        cycle(0, 0, 0, 0);
        n_checks++;
        if (act !== exp_vec()) begin n_fail++; $display("FAIL reset_release got %h exp %h", act, exp_vec()); end
    endtask

    task automatic test_scroll_in();
        for (int f = 1; f <= 64; f++) begin
            frame(0);
            n_checks++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL scroll_in frame %0d got %h exp %h", f, act, exp_vec()); end
            if (f == 1) begin
                n_checks++;
                if (st !== 3'd1 || y !== -11'sd100) begin n_fail++; $display("FAIL scroll_in_start got st=%0d y=%0d exp st=1 y=-100", st, y); end
            end
            if (f == 63) begin
                n_checks++;
                if (y !== 11'sd148 || st !== 3'd1) begin n_fail++; $display("FAIL scroll_in_f63 got st=%0d y=%0d exp st=1 y=148", st, y); end
            end
            if (f == 64) begin
                n_checks++;
                if (y !== 11'sd150 || st !== 3'd2 || pe !== 1'b1) begin n_fail++; $display("FAIL scroll_in_clamp got st=%0d y=%0d pe=%b exp st=2 y=150 pe=1", st, y, pe); end
            end
        end
    endtask

    task automatic test_blink();
        for (int f = 1; f <= 90; f++) begin
            frame(0);
            n_checks++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL blink frame %0d got %h exp %h", f, act, exp_vec()); end
            if (f == 29 || f == 30 || f == 60 || f == 90) begin
                n_checks++;
                if (pe !== ((f == 29 || f == 60) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL blink_toggle frame %0d got pe=%b", f, pe); end
            end
        end
    endtask

    task automatic test_scroll_out();
        int n;
        frame(1);
        n_checks++;
        if (st !== 3'd3 || pe !== 1'b0 || te !== 1'b1) begin n_fail++; $display("FAIL scroll_out_entry got st=%0d pe=%b te=%b exp st=3 pe=0 te=1", st, pe, te); end
        n = 0;
        while (st == 3'd3 && n < 100) begin
            frame(1);
            n++;
            n_checks++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL scroll_out frame %0d got %h exp %h", n, act, exp_vec()); end
            if (n == 1) begin
                n_checks++;
                if (y !== 11'sd146) begin n_fail++; $display("FAIL scroll_out_first got y=%0d exp 146", y); end
            end
        end
        n_checks++;
        if (n != 63 || st !== 3'd4 || y !== -11'sd100 || {te, wa, gs} !== 3'b001) begin
            n_fail++; $display("FAIL done_entry got frames=%0d st=%0d y=%0d te/wa/gs=%b exp 63 4 -100 001", n, st, y, {te, wa, gs});
        end
        cycle(0, 1, 0, 0);
        n_checks++;
        if (gs !== 1'b0 || st !== 3'd4) begin n_fail++; $display("FAIL game_start_width got gs=%b st=%0d exp gs=0 st=4", gs, st); end
        for (int i = 0; i < 6; i++) begin
            cycle(i[0], 0, 0, 0);
            n_checks++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL done_hold got %h exp %h", act, exp_vec()); end
        end
    endtask

    task automatic test_game_over();
        cycle(0, 0, 1, 0);
        n_checks++;
        if (st !== 3'd0 || wa !== 1'b1 || y !== -11'sd100 || te !== 1'b0) begin
            n_fail++; $display("FAIL game_over got st=%0d wa=%b y=%0d te=%b exp st=0 wa=1 y=-100 te=0", st, wa, y, te);
        end
        cycle(0, 0, 0, 0);
        n_checks++;
        if (act !== exp_vec()) begin n_fail++; $display("FAIL game_over_idle got %h exp %h", act, exp_vec()); end
    endtask

    task automatic test_key_skip();
        int n = 0;
        while (m_y != 20 && n < 100) begin
            frame(0);
            n++;
            n_checks++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL skip_approach got %h exp %h", act, exp_vec()); end
        end
        n_checks++;
        if (y !== 11'sd20 || st !== 3'd1) begin n_fail++; $display("FAIL skip_at20 got st=%0d y=%0d exp st=1 y=20", st, y); end
        frame(1);
        n_checks++;
        if (y !== 11'sd150 || st !== 3'd2 || pe !== 1'b1) begin n_fail++; $display("FAIL skip got st=%0d y=%0d pe=%b exp st=2 y=150 pe=1", st, y, pe); end
        for (int f = 0; f < 40; f++) begin
            frame(1);
            n_checks++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL held_key got %h exp %h", act, exp_vec()); end
        end
        n_checks++;
        if (st !== 3'd2) begin n_fail++; $display("FAIL held_key_state got st=%0d exp 2", st); end
    endtask

    task automatic test_coincident();
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        n_checks++;
        if (st !== 3'd2 || wa !== 1'b1) begin n_fail++; $display("FAIL game_over_ignored got st=%0d wa=%b exp st=2 wa=1", st, wa); end
        cycle(1, 0, 1, 0);
        n_checks++;
        if (act !== exp_vec() || st !== 3'd2) begin n_fail++; $display("FAIL game_over_ignored_sof got %h exp %h", act, exp_vec()); end
        cycle(1, 1, 0, 0);
        n_checks++;
        if (st !== 3'd3 || y !== 11'sd150 || pe !== 1'b0) begin n_fail++; $display("FAIL coincident_key got st=%0d y=%0d pe=%b exp st=3 y=150 pe=0", st, y, pe); end
    endtask

    task automatic test_reset_mid();
        for (int f = 0; f < 5; f++) frame(1);
        n_checks++;
        if (st !== 3'd3 || y !== 11'sd130) begin n_fail++; $display("FAIL mid_scroll_out got st=%0d y=%0d exp st=3 y=130", st, y); end
        cycle(1, 1, 0, 1);
        n_checks++;
        if (st !== 3'd0 || y !== -11'sd100 || x !== 11'd170 || {te, pe, wa, gs} !== 4'b0010) begin
            n_fail++; $display("FAIL reset_mid got st=%0d y=%0d x=%0d flags=%b exp st=0 y=-100 x=170 flags=0010", st, y, x, {te, pe, wa, gs});
        end
    endtask

    task automatic test_random();
        bit k = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) k = ~k;
            cycle($urandom_range(0, 3) == 0, k, $urandom_range(0, 40) == 0, $urandom_range(0, 999) == 0);
            n_checks++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL random cycle %0d got %h exp %h", i, act, exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_scroll_in();
        test_blink();
        test_scroll_out();
        test_game_over();
        test_key_skip();
        test_coincident();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
